// File: rtl/cuentas_arbiter_if.sv
// Bus between the four requesters and the arbiter that shares the count-select mux.
// The arbiter takes the slave side; the requesters (or a bench) take the master side.
`timescale 1ns/1ps

interface cuentas_arbiter_if;
  logic [3:0] req;
  logic [1:0] seleccion;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  seleccion,
    input  gnt,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output seleccion,
    output gnt,
    output busy,
    output timeout
  );
endinterface

// File: rtl/cuentas_arbiter.sv
// Round-robin arbiter for one shared 4:1 count-select mux, with optional hold timeout
// and a forced idle cycle between grants so the mux never switches under an active grant.
`timescale 1ns/1ps

module cuentas_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  cuentas_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX     = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST    = (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);
  localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);

  state_t            state_q,     state_d;
  logic [1:0]        ptr_q,       ptr_d;
  logic [1:0]        owner_q,     owner_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [1:0]        seleccion_q, seleccion_d;
  logic [3:0]        gnt_q,       gnt_d;
  logic              timeout_q,   timeout_d;

  logic              win_found;
  logic [1:0]        win_idx;

  // Scan from the highest offset down so the requester closest to ptr is taken last.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    seleccion_d = seleccion_q;
    gnt_d       = gnt_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win_found) begin
          state_d     = GRANT;
          owner_d     = win_idx;
          seleccion_d = win_idx;
          gnt_d       = 4'b0001 << win_idx;
          hold_cnt_d  = '0;
        end
      end

      GRANT: begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        // A voluntary drop wins over a coincident timeout, so no pulse in that case.
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end else if (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = owner_q + 2'd1;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      hold_cnt_q  <= '0;
      seleccion_q <= 2'b00;
      gnt_q       <= 4'b0000;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      seleccion_q <= seleccion_d;
      gnt_q       <= gnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.seleccion = seleccion_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_cuentas_arbiter.sv
// Bench for cuentas_arbiter: three instances (MAX_HOLD 16, 4, 0), directed scenarios,
// then randomized requests compared against a grant-length reference model.
`timescale 1ns/1ps

module tb_cuentas_arbiter;

  logic clk = 1'b0;
  bit   clk_run = 1'b1;
  logic reset_n;

  always #5 if (clk_run) clk = ~clk;

  cuentas_arbiter_if bus16 ();
  cuentas_arbiter_if bus4 ();
  cuentas_arbiter_if bus0 ();

  cuentas_arbiter #(.MAX_HOLD(16), .HOLD_W(8)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
  cuentas_arbiter #(.MAX_HOLD(4),  .HOLD_W(8)) dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));
  cuentas_arbiter #(.MAX_HOLD(0),  .HOLD_W(8)) dut0  (.clk(clk), .reset_n(reset_n), .bus(bus0));

  // Index 0 = dut16, 1 = dut4, 2 = dut0.
  logic [3:0] o_gnt  [3];
  logic [1:0] o_sel  [3];
  logic       o_busy [3];
  logic       o_to   [3];

  assign o_gnt[0] = bus16.gnt;  assign o_sel[0] = bus16.seleccion;
  assign o_busy[0] = bus16.busy; assign o_to[0] = bus16.timeout;
  assign o_gnt[1] = bus4.gnt;   assign o_sel[1] = bus4.seleccion;
  assign o_busy[1] = bus4.busy;  assign o_to[1] = bus4.timeout;
  assign o_gnt[2] = bus0.gnt;   assign o_sel[2] = bus0.seleccion;
  assign o_busy[2] = bus0.busy;  assign o_to[2] = bus0.timeout;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model: owner (-1 = idle), next-priority pointer, length of current grant.
  int   max_hold [3] = '{16, 4, 0};
  int   m_owner  [3];
  int   m_ptr    [3];
  int   m_len    [3];
  int   m_sel    [3];
  bit   m_to     [3];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkBus(input string tag, input int d, input logic [3:0] g,
                          input logic [1:0] s, input logic t);
    checkOutput({tag, "_gnt"},     32'(o_gnt[d]),  32'(g));
    checkOutput({tag, "_sel"},     32'(o_sel[d]),  32'(s));
    checkOutput({tag, "_busy"},    32'(o_busy[d]), 32'(g != 4'b0000));
    checkOutput({tag, "_timeout"}, 32'(o_to[d]),   32'(t));
  endtask

  task automatic applyStimulus(input logic [3:0] r16, input logic [3:0] r4, input logic [3:0] r0);
    @(negedge clk);
    bus16.req = r16;
    bus4.req  = r4;
    bus0.req  = r0;
    @(posedge clk);
    #1;
  endtask

  function automatic void modelReset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_len[d]   = 0;
      m_sel[d]   = 0;
      m_to[d]    = 1'b0;
    end
  endfunction

  function automatic void modelStep(input int d, input logic [3:0] r);
    m_to[d] = 1'b0;
    if (m_owner[d] < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[d] + k) % 4;
        if (r[c] && m_owner[d] < 0) begin
          m_owner[d] = c;
          m_sel[d]   = c;
          m_len[d]   = 1;
        end
      end
    end else if (!r[m_owner[d]]) begin
      m_ptr[d]   = (m_owner[d] + 1) % 4;
      m_owner[d] = -1;
    end else if (max_hold[d] != 0 && m_len[d] == max_hold[d]) begin
      m_ptr[d]   = (m_owner[d] + 1) % 4;
      m_owner[d] = -1;
      m_to[d]    = 1'b1;
    end else begin
      m_len[d] = m_len[d] + 1;
    end
  endfunction

  function automatic logic [3:0] modelGnt(input int d);
    return (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rq [3];
    bus16.req = 4'b0000;
    bus4.req  = 4'b0000;
    bus0.req  = 4'b0000;
    reset_n   = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) checkBus($sformatf("reset_d%0d", d), d, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester 2: grant after the first edge, release after the sixth.
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    checkBus("t2_grant", 0, 4'b0100, 2'd2, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      checkBus($sformatf("t2_hold%0d", k), 0, 4'b0100, 2'd2, 1'b0);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkBus("t2_release", 0, 4'b0000, 2'd2, 1'b0);
    // ptr now 3: with 0 and 3 both requesting, 3 must win.
    applyStimulus(4'b1001, 4'b0000, 4'b0000);
    checkBus("t2_ptr3", 0, 4'b1000, 2'd3, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkBus("t2_release3", 0, 4'b0000, 2'd3, 1'b0);

    // All four requesting; each owner drops after three grant cycles.
    for (int k = 0; k < 5; k++) begin
      int         o;
      logic [3:0] g;
      o = k % 4;
      g = 4'(1 << o);
      applyStimulus(4'b1111, 4'b0000, 4'b0000);
      checkBus($sformatf("t3_grant%0d", k), 0, g, 2'(o), 1'b0);
      for (int c = 0; c < 2; c++) begin
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        checkBus($sformatf("t3_hold%0d_%0d", k, c), 0, g, 2'(o), 1'b0);
      end
      applyStimulus(4'b1111 & ~g, 4'b0000, 4'b0000);
      checkBus($sformatf("t3_idle%0d", k), 0, 4'b0000, 2'(o), 1'b0);
    end

    // MAX_HOLD=4 timeout, regrant of the same lone requester, then 3 beats 1.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 4'b0010, 4'b0000);
      checkBus($sformatf("t4_first%0d", c), 1, 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0000, 4'b0010, 4'b0000);
    checkBus("t4_timeout1", 1, 4'b0000, 2'd1, 1'b1);
    applyStimulus(4'b0000, 4'b0010, 4'b0000);
    checkBus("t4_regrant", 1, 4'b0010, 2'd1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(4'b0000, 4'b1010, 4'b0000);
      checkBus($sformatf("t4_second%0d", c), 1, 4'b0010, 2'd1, 1'b0);
    end
    applyStimulus(4'b0000, 4'b1010, 4'b0000);
    checkBus("t4_timeout2", 1, 4'b0000, 2'd1, 1'b1);
    applyStimulus(4'b0000, 4'b1010, 4'b0000);
    checkBus("t4_next_is_3", 1, 4'b1000, 2'd3, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkBus("t4_release", 1, 4'b0000, 2'd3, 1'b0);

    // Short asynchronous reset pulse between edges while owner 2 holds dut16.
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    checkBus("t5_grant2", 0, 4'b0100, 2'd2, 1'b0);
    reset_n = 1'b0;
    #1;
    checkBus("t5_async16", 0, 4'b0000, 2'd0, 1'b0);
    checkBus("t5_async4", 1, 4'b0000, 2'd0, 1'b0);
    #2;
    reset_n = 1'b1;
    applyStimulus(4'b1010, 4'b0000, 4'b0000);
    checkBus("t5_grant1", 0, 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkBus("t5_release", 0, 4'b0000, 2'd1, 1'b0);

    // Unlimited hold: 300 cycles, no timeout, counter pinned at its maximum.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(4'b0000, 4'b0000, 4'b0001);
      checkBus($sformatf("t6_cycle%0d", n), 2, 4'b0001, 2'd0, 1'b0);
    end
    checkOutput("t6_hold_sat", 32'(dut0.hold_cnt_q), 32'd255);

    // Clock stopped mid-grant, then reset asserted.
    clk_run = 1'b0;
    #3;
    checkBus("t1_pre", 2, 4'b0001, 2'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) checkBus($sformatf("t1_stopped_d%0d", d), d, 4'b0000, 2'd0, 1'b0);
    #5;
    bus16.req = 4'b0000;
    bus4.req  = 4'b0000;
    bus0.req  = 4'b0000;
    reset_n   = 1'b1;
    #5;
    clk_run = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    for (int d = 0; d < 3; d++) checkBus($sformatf("t1_restart_d%0d", d), d, 4'b0000, 2'd0, 1'b0);

    // Randomized phase against the reference model.
    modelReset();
    for (int d = 0; d < 3; d++) rq[d] = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++) begin
        rq[d] = rq[d] ^ 4'($urandom & $urandom & $urandom);
        modelStep(d, rq[d]);
      end
      applyStimulus(rq[0], rq[1], rq[2]);
      for (int d = 0; d < 3; d++)
        checkBus($sformatf("rnd%0d_d%0d", n, d), d, modelGnt(d), 2'(m_sel[d]), m_to[d]);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
